// File: rtl/multicycle_controller.sv
// Purpose : multicycle RISC-V style control FSM (Moore) that sequences fetch, decode,
//           memory, execute and writeback steps and drives datapath enables/selects.
// Ports   : clk/rst (sync, active-high); opcode, zero, branch_neg, mem_ready (only
//           with MEM_WAIT_EN) in; pc_write, adr_src, mem_write, ir_write, reg_write,
//           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal, state out.
// Config  : define MEM_WAIT_EN to add mem_ready; FETCH, MEMREAD and MEMWRITE then stall
//           until memory is ready. Without it memory is always treated as ready.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       branch_neg,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state_r;
  state_t state_nxt;

  // Effective memory handshake; constant 1 when the wait feature is compiled out.
  logic mem_rdy;
`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // Raw per-state values before the reset override.
  logic       pc_update;
  logic       branch;
  logic       adr_src_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;
  logic [1:0] result_src_raw;
  logic [1:0] alu_src_a_raw;
  logic [1:0] alu_src_b_raw;
  logic [1:0] alu_op_raw;

  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_nxt;
  end

  always_comb begin
    state_nxt      = S_FETCH;
    pc_update      = 1'b0;
    branch         = 1'b0;
    adr_src_raw    = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    illegal_raw    = 1'b0;
    result_src_raw = 2'b00;
    alu_src_a_raw  = 2'b00;
    alu_src_b_raw  = 2'b00;
    alu_op_raw     = 2'b00;
    case (state_r)
      S_FETCH: begin
        // PC+4 on the ALU; IR load and PC update only once the fetch completes.
        ir_write_raw   = mem_rdy;
        pc_update      = mem_rdy;
        alu_src_b_raw  = 2'b10;
        result_src_raw = 2'b10;
        state_nxt      = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // oldPC + imm precomputes the branch/jump target.
        alu_src_a_raw = 2'b01;
        alu_src_b_raw = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BR:        state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            illegal_raw = 1'b1;
            state_nxt   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_raw = 2'b10;
        alu_src_b_raw = 2'b01;
        state_nxt     = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_raw = 1'b1;
        state_nxt   = mem_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_raw = 2'b01;
        reg_write_raw  = 1'b1;
      end
      S_MEMWRITE: begin
        // Write strobe is held for the whole stall, not just the final cycle.
        adr_src_raw   = 1'b1;
        mem_write_raw = 1'b1;
        state_nxt     = mem_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_raw = 2'b10;
        alu_op_raw    = 2'b10;
        state_nxt     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_raw = 2'b10;
        alu_src_b_raw = 2'b01;
        alu_op_raw    = 2'b10;
        state_nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_raw = 2'b10;
        alu_op_raw    = 2'b01;
        branch        = 1'b1;
      end
      S_JAL: begin
        alu_src_a_raw = 2'b01;
        alu_src_b_raw = 2'b10;
        pc_update     = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset wins immediately, so an instruction in flight cannot write anything in
  // the cycle reset is raised; selects park at their FETCH values.
  always_comb begin
    if (rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      result_src = 2'b10;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b10;
      alu_op     = 2'b00;
    end else begin
      // branch_neg=1 takes the branch on zero=1, branch_neg=0 on zero=0.
      pc_write   = pc_update | (branch & ~(zero ^ branch_neg));
      adr_src    = adr_src_raw;
      mem_write  = mem_write_raw;
      ir_write   = ir_write_raw;
      reg_write  = reg_write_raw;
      illegal    = illegal_raw;
      result_src = result_src_raw;
      alu_src_a  = alu_src_a_raw;
      alu_src_b  = alu_src_b_raw;
      alu_op     = alu_op_raw;
    end
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose : self-checking bench for multicycle_controller; per-cycle expected outputs
//           are queued when stimulus is driven and compared on the falling edge.
// Ports   : none (top-level bench); MEM_WAIT_EN adds the memory-stall sequence.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal;
    logic [3:0] state;
  } out_t;

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        bn;
    int          len;
    logic [19:0] seq;   // expected state per cycle, one nibble each, cycle 0 lowest
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       branch_neg = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state;

  out_t act;
  assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, imm_src, illegal, state};

  out_t exp_q[$];
  int   id_q[$];
  int   errors = 0;
  int   checks = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .branch_neg (branch_neg),
`ifdef MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Expected outputs written straight from the per-state output table.
  function automatic out_t exp_out(input logic [3:0] s, input logic [6:0] op,
                                   input logic z, input logic bn,
                                   input logic mr, input logic r);
    out_t e;
    e = '0;
    e.state = s;
    if (op == 7'b0100011)      e.imm_src = 2'b01;
    else if (op == 7'b1100011) e.imm_src = 2'b10;
    else if (op == 7'b1101111) e.imm_src = 2'b11;
    if (r) begin
      e.result_src = 2'b10;
      e.alu_src_b  = 2'b10;
      return e;
    end
    case (s)
      4'd0: begin e.ir_write = mr; e.pc_write = mr; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      4'd1: begin
        e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
        e.illegal = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                      op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111);
      end
      4'd2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      4'd3:  e.adr_src = 1'b1;
      4'd4:  begin e.result_src = 2'b01; e.reg_write = 1'b1; end
      4'd5:  begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
      4'd6:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
      4'd7:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
      4'd8:  e.reg_write = 1'b1;
      4'd9:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = (z == bn); end
      4'd10: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock of stimulus; the expected outputs for that cycle go on the scoreboard.
  task automatic step(input logic [6:0] op, input logic z, input logic bn,
                      input logic mr, input logic r, input logic [3:0] s, input int id);
    @(posedge clk);
    #1;
    opcode     = op;
    zero       = z;
    branch_neg = bn;
    mem_ready  = mr;
    rst        = r;
    exp_q.push_back(exp_out(s, op, z, bn, mem_ready, r));
    id_q.push_back(id);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL seq%0d_cyc%0d: actual=%05h required=%05h (actual state=%0d required state=%0d)",
                 id / 16, id % 16, act, e, act.state, e.state);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    vt[0]  = '{7'b0000011, 1'b0, 1'b0, 5, 20'h43210};  // lw
    vt[1]  = '{7'b0100011, 1'b0, 1'b0, 4, 20'h05210};  // sw
    vt[2]  = '{7'b0110011, 1'b0, 1'b0, 4, 20'h08610};  // R-type
    vt[3]  = '{7'b0010011, 1'b0, 1'b0, 4, 20'h08710};  // I-type
    vt[4]  = '{7'b1100011, 1'b1, 1'b1, 3, 20'h00910};  // branch taken on zero
    vt[5]  = '{7'b1100011, 1'b0, 1'b1, 3, 20'h00910};  // not taken
    vt[6]  = '{7'b1100011, 1'b0, 1'b0, 3, 20'h00910};  // taken on nonzero
    vt[7]  = '{7'b1100011, 1'b1, 1'b0, 3, 20'h00910};  // not taken
    vt[8]  = '{7'b1101111, 1'b0, 1'b0, 3, 20'h00A10};  // jal
    vt[9]  = '{7'b1111111, 1'b0, 1'b0, 2, 20'h00010};  // unsupported
    vt[10] = '{7'b0000000, 1'b1, 1'b1, 2, 20'h00010};  // unsupported

    // Reset held for two edges: state parks in FETCH with all strobes off.
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 0);
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1);

    for (int v = 0; v < 11; v++) begin
      for (int c = 0; c < vt[v].len; c++) begin
        logic [19:0] sq;
        sq = vt[v].seq;
        step(vt[v].op, vt[v].z, vt[v].bn, 1'b1, 1'b0, sq[4*c +: 4], (v + 1) * 16 + c);
      end
    end

    // Reset raised during MEMWRITE of a sw kills the write in the same cycle.
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12 * 16 + 0);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 12 * 16 + 1);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 12 * 16 + 2);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 12 * 16 + 3);
    step(7'b1101111, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12 * 16 + 4);
    step(7'b1101111, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 12 * 16 + 5);
    step(7'b1101111, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 12 * 16 + 6);
    step(7'b1101111, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12 * 16 + 7);

`ifdef MEM_WAIT_EN
    // Fetch stall, then sw whose MEMWRITE waits three cycles for mem_ready.
    step(7'b0100011, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 13 * 16 + 0);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 13 * 16 + 1);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 13 * 16 + 2);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 13 * 16 + 3);
    for (int c = 0; c < 3; c++)
      step(7'b0100011, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 13 * 16 + 4 + c);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 13 * 16 + 7);
    // lw whose MEMREAD stalls one cycle.
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 14 * 16 + 0);
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 14 * 16 + 1);
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 14 * 16 + 2);
    step(7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 14 * 16 + 3);
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 14 * 16 + 4);
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 14 * 16 + 5);
    step(7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 14 * 16 + 6);
`endif

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d entries left, required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
